// File: rtl/padding_pkg.sv
// Shared types and helpers for the padded sliding-window row buffer.
// Localparams describe the default 416x416x3, PAD=1 configuration.
package padding_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_IMG_W  = 416;
    localparam int unsigned DEF_CH     = 3;
    localparam int unsigned DEF_PAD    = 1;

    localparam int unsigned K        = 2 * DEF_PAD + 1;
    localparam int unsigned PW       = DEF_IMG_W + 2 * DEF_PAD;
    localparam int unsigned ROW_BITS = DEF_CH * PW * DEF_DATA_W;
    localparam int unsigned IN_BITS  = DEF_CH * DEF_IMG_W * DEF_DATA_W;

    // Unpadded row to padded row for the default configuration.
    function automatic logic [ROW_BITS-1:0] pad_row(input logic [IN_BITS-1:0] row);
        logic [ROW_BITS-1:0] r;
        r = '0;
        for (int unsigned c = 0; c < DEF_CH; c++) begin
            for (int unsigned j = 0; j < DEF_IMG_W; j++) begin
                r[(c * PW + j + DEF_PAD) * DEF_DATA_W +: DEF_DATA_W] =
                    row[(c * DEF_IMG_W + j) * DEF_DATA_W +: DEF_DATA_W];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pad_row_fmt.sv
// Combinational zero insertion: CH*IMG_W pixels in, CH*(IMG_W+2*PAD) pixels out.
module pad_row_fmt
    import padding_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 416,
    parameter int unsigned CH     = 3,
    parameter int unsigned PAD    = 1
) (
    input  logic [CH*IMG_W*DATA_W-1:0]         row_i,
    output logic [CH*(IMG_W+2*PAD)*DATA_W-1:0] row_o
);

    localparam int unsigned NPW = IMG_W + 2 * PAD;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar p = 0; p < NPW; p++) begin : g_px
            if (p < PAD || p >= IMG_W + PAD) begin : g_zero
                assign row_o[(c*NPW+p)*DATA_W +: DATA_W] = '0;
            end else begin : g_data
                assign row_o[(c*NPW+p)*DATA_W +: DATA_W] =
                    row_i[(c*IMG_W+p-PAD)*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/padding_window_gen.sv
// K-row sliding window over zero-padded image rows, with top/bottom zero borders
// and valid/ready handshakes on both sides.
module padding_window_gen
    import padding_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 416,
    parameter int unsigned IMG_H  = 416,
    parameter int unsigned CH     = 3,
    parameter int unsigned PAD    = 1
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         clr,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [CH*IMG_W*DATA_W-1:0]                   in_row,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [(2*PAD+1)*CH*(IMG_W+2*PAD)*DATA_W-1:0] out_win,
    output logic [$clog2(IMG_H)-1:0]                     out_row_idx,
    output logic                                         out_last
);

    localparam int unsigned NK       = 2 * PAD + 1;
    localparam int unsigned NPW      = IMG_W + 2 * PAD;
    localparam int unsigned NRB      = CH * NPW * DATA_W;
    localparam int unsigned WIN_BITS = NK * NRB;
    localparam int unsigned CNT_W    = $clog2(IMG_H + 1);
    localparam int unsigned IDX_W    = $clog2(IMG_H);

    localparam logic [CNT_W-1:0] H_CNT    = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] FILL_CNT = CNT_W'(PAD + 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [NRB-1:0]      padded;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [WIN_BITS-1:0] win_q, win_d;
    logic                out_valid_q, out_last_q;
    logic [IDX_W-1:0]    out_idx_q;
    logic                in_fire, out_fire;

    pad_row_fmt #(
        .DATA_W(DATA_W),
        .IMG_W (IMG_W),
        .CH    (CH),
        .PAD   (PAD)
    ) u_fmt (
        .row_i(in_row),
        .row_o(padded)
    );

    // Next-state, counters and window shift; newest row lands in the top slice.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        win_d     = win_q;
        in_ready  = 1'b0;

        unique case (state_q)
            FILL:    in_ready = 1'b1;
            HOLD:    in_ready = out_ready && (in_cnt_q < H_CNT);
            WAIT:    in_ready = 1'b1;
            default: in_ready = 1'b0;
        endcase
        if (!rst_n || clr) begin
            in_ready = 1'b0;
        end

        in_fire  = in_valid && in_ready;
        out_fire = (state_q == HOLD) && out_ready;

        case (state_q)
            FILL: begin
                if (in_fire) begin
                    win_d    = {padded, win_q[WIN_BITS-1:NRB]};
                    in_cnt_d = in_cnt_q + ONE;
                    if (in_cnt_d == FILL_CNT) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    out_cnt_d = out_cnt_q + ONE;
                    if (out_cnt_q == LAST_CNT) begin
                        win_d     = '0;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                        state_d   = FILL;
                    end else if (in_cnt_q < H_CNT) begin
                        if (in_fire) begin
                            win_d    = {padded, win_q[WIN_BITS-1:NRB]};
                            in_cnt_d = in_cnt_q + ONE;
                        end else begin
                            state_d = WAIT;
                        end
                    end else begin
                        // Bottom border: all input rows consumed, shift in zeros.
                        win_d = {NRB'(0), win_q[WIN_BITS-1:NRB]};
                    end
                end
            end
            WAIT: begin
                if (in_fire) begin
                    win_d    = {padded, win_q[WIN_BITS-1:NRB]};
                    in_cnt_d = in_cnt_q + ONE;
                    state_d  = HOLD;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, window and registered sideband outputs; clr acts as a frame reset.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state_q     <= FILL;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            win_q       <= win_d;
            out_valid_q <= (state_d == HOLD);
            out_last_q  <= (state_d == HOLD) && (out_cnt_d == LAST_CNT);
            out_idx_q   <= IDX_W'(out_cnt_d);
        end
    end

    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_row_idx = out_idx_q;
    assign out_win     = win_q;

endmodule

// File: tb/tb_padding_window_gen.sv
// Directed bench for padding_window_gen: a window model computed from image
// coordinates is checked every cycle, plus literal pixel checks.
module tb_padding_window_gen;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IMG_W  = 4;
    localparam int unsigned IMG_H  = 4;
    localparam int unsigned CH     = 3;
    localparam int unsigned PAD    = 1;
    localparam int unsigned K      = 2 * PAD + 1;
    localparam int unsigned PW     = IMG_W + 2 * PAD;
    localparam int unsigned RB     = CH * PW * DATA_W;
    localparam int unsigned WB     = K * RB;
    localparam int unsigned IB     = CH * IMG_W * DATA_W;
    localparam int unsigned IDX_W  = $clog2(IMG_H);

    logic             clk = 1'b0;
    logic             rst_n, clr, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [IB-1:0]    in_row;
    logic [WB-1:0]    out_win;
    logic [IDX_W-1:0] out_row_idx;

    int               n_cmp = 0;
    int               n_err = 0;
    int               next_n = 0;
    int               exp_idx = 0;
    bit               in_en = 1'b0;
    bit               prev_stall = 1'b0;
    logic [WB-1:0]    prev_win = '0;

    padding_window_gen #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .PAD(PAD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_win(out_win),
        .out_row_idx(out_row_idx), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pix(int n, int c, int j);
        return DATA_W'(32'h10 * n + j + 32'h40 * c);
    endfunction

    function automatic logic [IB-1:0] mk_row(int n);
        logic [IB-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++)
            for (int j = 0; j < IMG_W; j++)
                r[(c*IMG_W+j)*DATA_W +: DATA_W] = pix(n, c, j);
        return r;
    endfunction

    // Window centred on image row r: slot k shows image row r+k-PAD, zero outside the image.
    function automatic logic [WB-1:0] exp_win(int r);
        logic [WB-1:0] w;
        int src;
        w = '0;
        for (int k = 0; k < K; k++) begin
            src = r + k - PAD;
            for (int c = 0; c < CH; c++)
                for (int p = 0; p < PW; p++)
                    if (src >= 0 && src < IMG_H && p >= PAD && p < IMG_W + PAD)
                        w[((k*CH+c)*PW+p)*DATA_W +: DATA_W] = pix(src, c, p - PAD);
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle model comparison plus row-acceptance bookkeeping.
    always @(negedge clk) begin
        if (out_valid) begin
            n_cmp++;
            if (out_win !== exp_win(exp_idx)) begin
                n_err++;
                $display("FAIL win[%0d]: got %h expected %h", exp_idx, out_win, exp_win(exp_idx));
            end
            chk("row_idx", 64'(out_row_idx), 64'(exp_idx));
            chk("last", 64'(out_last), 64'(exp_idx == IMG_H - 1));
        end
        if (prev_stall) begin
            n_cmp++;
            if (out_win !== prev_win || !out_valid) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%0b win=%h expected valid=1 win=%h",
                         out_valid, out_win, prev_win);
            end
        end
        prev_stall = out_valid && !out_ready && rst_n && !clr;
        prev_win   = out_win;

        if (!rst_n || clr) begin
            exp_idx = 0;
            next_n  = 0;
        end else begin
            if (in_valid && in_ready) next_n++;
            if (out_valid && out_ready) begin
                if (exp_idx == IMG_H - 1) begin
                    chk("rows_in_frame", 64'(next_n), 64'(IMG_H));
                    exp_idx = 0;
                    next_n  = 0;
                end else begin
                    exp_idx++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid = in_en && (next_n < IMG_H);
        in_row   = mk_row(next_n < IMG_H ? next_n : 0);
    endtask

    task automatic start_frame();
        in_en    = 1'b1;
        in_valid = (next_n < IMG_H);
        in_row   = mk_row(next_n < IMG_H ? next_n : 0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        n_cmp++;
        if (!out_valid) begin
            n_err++;
            $display("FAIL %s: got out_valid=0 expected 1 within 20 cycles", name);
        end
    endtask

    task automatic run_to_end(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (out_valid && out_last && out_ready) begin
                in_en = 1'b0;
                done  = 1'b1;
            end
            step();
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_idle"}, 64'(out_valid), 64'd0);
        chk({name, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; out_ready = 1'b1; in_valid = 1'b0; in_row = '0;
        step(); step();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_win_zero", 64'(|out_win), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'(in_ready), 64'd1);

        // Frame 1: back-to-back stream and bottom flush.
        start_frame();
        step();
        chk("fill_no_valid", 64'(out_valid), 64'd0);
        step();
        chk("w0_valid", 64'(out_valid), 64'd1);
        chk("w0_idx", 64'(out_row_idx), 64'd0);
        chk("w0_k0_zero", 64'(|out_win[RB-1:0]), 64'd0);
        chk("w0_k1_ch0", 64'(out_win[RB +: 48]), 64'h0000_0003_0201_0000);
        chk("w0_k2_ch0", 64'(out_win[2*RB +: 48]), 64'h0000_0013_1211_1000);
        chk("w0_k1_ch1_p1", 64'(out_win[(1*CH+1)*PW*DATA_W + DATA_W +: DATA_W]), 64'h40);
        step();
        chk("w1_valid", 64'(out_valid), 64'd1);
        chk("w1_idx", 64'(out_row_idx), 64'd1);
        step();
        chk("w2_idx", 64'(out_row_idx), 64'd2);
        step();
        chk("w3_valid", 64'(out_valid), 64'd1);
        chk("w3_idx", 64'(out_row_idx), 64'd3);
        chk("w3_last", 64'(out_last), 64'd1);
        chk("w3_k2_zero", 64'(|out_win[2*RB +: RB]), 64'd0);
        in_en = 1'b0;
        step();
        chk("end_idle", 64'(out_valid), 64'd0);
        chk("end_ready", 64'(in_ready), 64'd1);

        // Frame 2: three cycles of output backpressure mid-frame.
        start_frame();
        wait_valid("bp_w0");
        step();
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready0", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_idx", 64'(out_row_idx), 64'd1);
        end
        out_ready = 1'b1;
        run_to_end("bp");

        // Frame 3: input gap after window 0 fires.
        start_frame();
        wait_valid("gap_w0");
        in_en = 1'b0; in_valid = 1'b0;
        step();
        chk("gap_valid_a", 64'(out_valid), 64'd0);
        chk("gap_ready_a", 64'(in_ready), 64'd1);
        step();
        chk("gap_valid_b", 64'(out_valid), 64'd0);
        start_frame();
        step();
        chk("gap_w1_valid", 64'(out_valid), 64'd1);
        chk("gap_w1_idx", 64'(out_row_idx), 64'd1);
        run_to_end("gap");

        // Frame 4: abort after two windows, then a clean frame.
        start_frame();
        wait_valid("abort_w0");
        step(); step();
        chk("abort_pre_idx", 64'(out_row_idx), 64'd2);
        clr = 1'b1;
        #1;
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        step();
        clr = 1'b0;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_win_zero", 64'(|out_win), 64'd0);
        wait_valid("post_abort_w0");
        chk("post_abort_idx", 64'(out_row_idx), 64'd0);
        chk("post_abort_k0_zero", 64'(|out_win[RB-1:0]), 64'd0);
        chk("post_abort_k1_ch0", 64'(out_win[RB +: 48]), 64'h0000_0003_0201_0000);
        run_to_end("post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/padding_window_gen.md
Name: padding_window_gen

Overview:
- Parametrised successor to the fixed 416-pixel, 3-channel, 1-pixel padding row buffer.
- Accepts one unpadded image row per handshake, adds PAD zero pixels left and right, and keeps a K=2*PAD+1 row sliding window.
- Emits one complete padded window per output row, including the top and bottom zero-row borders.
- Sits between the input row streamer and the first convolution layer; a valid/ready handshake replaces the free-running en.

Parameters:
- DATA_W, 8, bits per pixel
- IMG_W, 416, pixels per unpadded row
- IMG_H, 416, rows per frame; must be >= PAD+1
- CH, 3, channel count
- PAD, 1, zero-padding width on each side, range 1..3; K=2*PAD+1, PW=IMG_W+2*PAD

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- clr  in  1  synchronous frame abort; same effect as reset
- in_valid  in  1  in_row holds a row
- in_ready  out  1  block accepts a row this cycle
- in_row  in  CH*IMG_W*DATA_W  channel c pixel j at [(c*IMG_W+j)*DATA_W +: DATA_W]
- out_valid  out  1  out_win holds a valid window
- out_ready  in  1  consumer takes the window
- out_win  out  K*CH*PW*DATA_W  row k (0=top), channel c, padded pixel p at [((k*CH+c)*PW+p)*DATA_W +: DATA_W]
- out_row_idx  out  clog2(IMG_H)  centre-row index of the current window
- out_last  out  1  high with out_valid on the final window of the frame

Behaviour:
- Reset (rst_n=0 or clr=1 at the clock edge):
  - window buffer cleared to zero; in_cnt=0, out_cnt=0, state=FILL
  - out_valid=0, out_last=0, out_row_idx=0
  - in_ready forced 0 while rst_n=0 or clr=1
  - clr takes priority over any handshake in the same cycle
- Padding: padded pixel p=j+PAD equals input pixel j; p<PAD and p>=IMG_W+PAD are 0 in every row and channel.
- Shift: the newest row enters at k=K-1; each row moves k to k-1; row 0 is discarded. out_win is the buffer register itself.
- FILL state: in_ready=1, out_valid=0.
  - On accept: shift in the row, in_cnt++.
  - When in_cnt reaches PAD+1, go to HOLD. This puts PAD zero rows at the top of the first window.
- HOLD state: out_valid=1, out_row_idx=out_cnt, out_last=(out_cnt==IMG_H-1).
  - in_ready = out_ready && in_cnt<IMG_H.
  - On out fire, out_cnt++, then:
    - if out_cnt was IMG_H-1: clear buffer and counters, go to FILL (frame end; in_ready is 0 this cycle).
    - else if in_cnt<IMG_H and in fire in the same cycle: shift in the row, in_cnt++, stay in HOLD (back-to-back, full throughput).
    - else if in_cnt<IMG_H and no in fire: go to WAIT; buffer unchanged.
    - else (in_cnt==IMG_H): shift in an all-zero row, stay in HOLD. This is the bottom-border flush and emits PAD trailing windows.
  - With out_ready=0, out_win and the sideband outputs hold stable and no input is accepted.
- WAIT state: out_valid=0, in_ready=1. On accept: shift in the row, in_cnt++, go to HOLD.
- Latency: a window is valid one cycle after the accepting edge of its last required row. Steady state is 1 window per cycle.
- Per frame: exactly IMG_H inputs and IMG_H windows. out_row_idx is 0..IMG_H-1 and increments by 1.
- Counter widths: in_cnt and out_cnt are clog2(IMG_H+1) bits. No wrap inside a frame.

Decomposition:
- Package padding_pkg:
  - FSM state enum: FILL, HOLD, WAIT
  - localparams K, PW, ROW_BITS=CH*PW*DATA_W
  - function pad_row(): unpadded row to padded row
- One sub-module pad_row_fmt: combinational zero insertion, CH*IMG_W to CH*PW, reused by later layers.
- FSM, counters and window register stay in the top.

Test Plan:
- Bench parameters: DATA_W=8, IMG_W=4, CH=3, PAD=1, IMG_H=4; row n pixels = 8'h10*n+j.
- Reset: hold rst_n=0 for 2 cycles -> out_valid=0, out_win=0, in_ready=0; after release in_ready=1.
- Back-to-back stream, out_ready=1 -> first window one cycle after row 1 is accepted:
  - k0 all zero; k1 = 00,00,01,02,03,00 (p=0..5); k2 = 00,10,11,12,13,00
  - windows 1, 2, 3 follow on consecutive cycles
- Flush: window 3 has k2 all zero, out_last=1, out_row_idx=3; next cycle state=FILL, in_ready=1, out_valid=0.
- Backpressure: out_ready=0 for 3 cycles mid-frame -> out_win stable, in_ready=0, no row lost; resume with the same row order.
- Gapped input: in_valid low for 2 cycles after window 0 fires -> out_valid=0 (WAIT); the next row gives window 1 one cycle later.
- Abort: clr=1 after 2 windows -> next cycle buffer zero, out_valid=0; the following frame starts from out_row_idx=0 with correct top padding.
